// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: opcodes, funct3 size codes,
// FSM state encoding and a funct3 legality helper.
package mem_stage_pkg;

    localparam logic [6:0] LOAD_OP   = 7'b0000011;
    localparam logic [6:0] STORE_OP  = 7'b0100011;
    localparam logic [6:0] OP_IMM_OP = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] LUI_OP    = 7'b0110111;
    localparam logic [6:0] AUIPC_OP  = 7'b0010111;
    localparam logic [6:0] JAL_OP    = 7'b1101111;
    localparam logic [6:0] JALR_OP   = 7'b1100111;
    localparam logic [6:0] BRANCH_OP = 7'b1100011;

    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_HALF  = 3'b001;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_BYTEU = 3'b100;
    localparam logic [2:0] F3_HALFU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Unsigned sizes exist only for loads; stores accept the three signed codes.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_BYTE, F3_HALF, F3_WORD: ok = 1'b1;
            F3_BYTEU, F3_HALFU:        ok = ~is_store;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/halfword out of the loaded word and sign- or
// zero-extends it according to funct3.
module load_align (
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);
    import mem_stage_pkg::*;

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by extension.
    always_comb begin
        byte_s    = mem_rdata[7:0];
        half_s    = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (offset)
            2'd0:    byte_s = mem_rdata[7:0];
            2'd1:    byte_s = mem_rdata[15:8];
            2'd2:    byte_s = mem_rdata[23:16];
            2'd3:    byte_s = mem_rdata[31:24];
            default: byte_s = mem_rdata[7:0];
        endcase
        case (funct3)
            F3_BYTE:  load_data = {{24{byte_s[7]}}, byte_s};
            F3_HALF:  load_data = {{16{half_s[15]}}, half_s};
            F3_BYTEU: load_data = {24'h000000, byte_s};
            F3_HALFU: load_data = {16'h0000, half_s};
            default:  load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding req/ack data-memory transaction for
// loads and stores, pass-through of the execute result for everything else.
module mem_stage #(
    parameter logic [6:0] LOAD_OP  = mem_stage_pkg::LOAD_OP,
    parameter logic [6:0] STORE_OP = mem_stage_pkg::STORE_OP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] c,
    input  logic [31:0] data2,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] result,
    output logic        mem_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    import mem_stage_pkg::*;

    state_t      state_r;
    logic [31:0] c_r;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic        is_load_r;

    logic        is_load_s;
    logic        is_store_s;
    logic        legal_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] load_data_s;

    assign stall = (state_r == ACCESS);

    // Decode legality, byte enables and replicated store data from the incoming op.
    always_comb begin
        is_load_s  = (opcode == LOAD_OP);
        is_store_s = (opcode == STORE_OP);
        legal_s    = 1'b0;
        be_s       = 4'b0000;
        wdata_s    = data2;
        case (funct3)
            F3_BYTE, F3_BYTEU: begin
                legal_s = 1'b1;
                be_s    = 4'b0001 << c[1:0];
                wdata_s = {4{data2[7:0]}};
            end
            F3_HALF, F3_HALFU: begin
                legal_s = ~c[0];
                be_s    = 4'b0011 << {c[1], 1'b0};
                wdata_s = {2{data2[15:0]}};
            end
            F3_WORD: begin
                legal_s = (c[1:0] == 2'b00);
                be_s    = 4'b1111;
                wdata_s = data2;
            end
            default: begin
                legal_s = 1'b0;
                be_s    = 4'b0000;
                wdata_s = data2;
            end
        endcase
        if (f3_legal(is_store_s, funct3)) begin
            legal_s = legal_s & (is_load_s | is_store_s);
        end else begin
            legal_s = 1'b0;
        end
    end

    load_align u_load_align (
        .mem_rdata (mem_rdata),
        .offset    (off_r),
        .funct3    (f3_r),
        .load_data (load_data_s)
    );

    // Stage FSM; valid_out defaults low so it only pulses on retirement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            valid_out <= 1'b0;
            result    <= 32'h0000_0000;
            mem_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0000_0000;
            c_r       <= 32'h0000_0000;
            f3_r      <= 3'b000;
            off_r     <= 2'b00;
            is_load_r <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (valid_in) begin
                        if (!(is_load_s || is_store_s)) begin
                            result    <= c;
                            valid_out <= 1'b1;
                            mem_err   <= 1'b0;
                        end else if (legal_s) begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store_s;
                            mem_addr  <= {c[31:2], 2'b00};
                            mem_be    <= be_s;
                            mem_wdata <= wdata_s;
                            c_r       <= c;
                            f3_r      <= funct3;
                            off_r     <= c[1:0];
                            is_load_r <= is_load_s;
                            state_r   <= ACCESS;
                        end else begin
                            result    <= 32'h0000_0000;
                            valid_out <= 1'b1;
                            mem_err   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        valid_out <= 1'b1;
                        mem_err   <= 1'b0;
                        result    <= is_load_r ? load_data_s : c_r;
                        state_r   <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// multi-cycle sequences and randomized transactions against a reference model.
module tb_mem_stage;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ADD = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n, valid_in, mem_ack;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] c, data2, mem_rdata;
    logic        stall, valid_out, mem_err, mem_req, mem_we;
    logic [31:0] result, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode),
        .funct3(funct3), .c(c), .data2(data2), .stall(stall),
        .valid_out(valid_out), .result(result), .mem_err(mem_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] cv;
        logic [31:0] d2;
        logic [31:0] rd;
        int          delay;
        bit          gap;
        logic        exp_req;
        logic        exp_we;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_res;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: what the bus and write-back should see for one op.
    function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] cv, input logic [31:0] d2,
                                  input logic [31:0] rd, output vec_t v);
        logic        ld, st, f3ok;
        logic [31:0] size, off, mask, val;
        ld   = (op == LD);
        st   = (op == ST);
        size = (f3[1:0] == 2'd0) ? 32'd1 : (f3[1:0] == 2'd1) ? 32'd2 :
               (f3[1:0] == 2'd2) ? 32'd4 : 32'd0;
        f3ok = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        off  = {30'b0, cv[1:0]};
        v.op = op; v.f3 = f3; v.cv = cv; v.d2 = d2; v.rd = rd;
        v.delay = 0; v.gap = 1'b1;
        v.exp_req = 1'b0; v.exp_we = 1'b0; v.exp_err = 1'b0;
        v.exp_be = 4'h0; v.exp_wd = 32'h0; v.exp_res = cv;
        if (ld || st) begin
            if (f3ok && size != 32'd0 && (off % size) == 32'd0) begin
                v.exp_req = 1'b1;
                v.exp_we  = st;
                v.exp_be  = 4'(((32'd1 << size) - 32'd1) << off);
                v.exp_wd  = (size == 32'd1) ? {24'b0, d2[7:0]} * 32'h01010101 :
                            (size == 32'd2) ? {16'b0, d2[15:0]} * 32'h00010001 : d2;
                if (ld) begin
                    mask = (size == 32'd4) ? 32'hFFFF_FFFF : (32'd1 << (32'd8 * size)) - 32'd1;
                    val  = (rd >> (32'd8 * off)) & mask;
                    if (!f3[2] && size < 32'd4 && val[32'd8 * size - 32'd1]) val = val | ~mask;
                    v.exp_res = val;
                end
            end else begin
                v.exp_err = 1'b1;
                v.exp_res = 32'h0;
            end
        end
    endfunction

    task automatic run_txn(input vec_t v);
        int stall_cnt;
        opcode = v.op; funct3 = v.f3; c = v.cv; data2 = v.d2;
        valid_in = 1'b1; mem_ack = 1'b0;
        step();
        valid_in = 1'b0; opcode = 7'b0; c = $urandom; data2 = $urandom;
        if (v.exp_req) begin
            stall_cnt = 0;
            for (int i = 0; i <= v.delay; i++) begin
                chk("mem_req_held", {31'b0, mem_req}, 32'd1);
                chk("mem_addr", mem_addr, {v.cv[31:2], 2'b00});
                chk("mem_be", {28'b0, mem_be}, {28'b0, v.exp_be});
                chk("mem_we", {31'b0, mem_we}, {31'b0, v.exp_we});
                if (v.exp_we) chk("mem_wdata", mem_wdata, v.exp_wd);
                chk("valid_out_pending", {31'b0, valid_out}, 32'd0);
                if (stall) stall_cnt++;
                if (i == v.delay) begin
                    mem_ack = 1'b1; mem_rdata = v.rd;
                end else begin
                    mem_rdata = $urandom;
                end
                step();
            end
            mem_ack = 1'b0; mem_rdata = $urandom;
            chk("stall_cycles", 32'(stall_cnt), 32'(v.delay + 1));
        end
        chk("valid_out", {31'b0, valid_out}, 32'd1);
        chk("result", result, v.exp_res);
        chk("mem_err", {31'b0, mem_err}, {31'b0, v.exp_err});
        chk("mem_req_after", {31'b0, mem_req}, 32'd0);
        chk("stall_after", {31'b0, stall}, 32'd0);
        if (v.gap) begin
            step();
            chk("valid_out_pulse", {31'b0, valid_out}, 32'd0);
            chk("mem_req_idle", {31'b0, mem_req}, 32'd0);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        chk({tag, "_valid_out"}, {31'b0, valid_out}, 32'd0);
        chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_mem_err"}, {31'b0, mem_err}, 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_be"}, {28'b0, mem_be}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    vec_t tbl[14];

    initial begin
        vec_t v;
        // op f3 c d2 rd delay gap | req we err be wdata result
        tbl[0]  = '{LD,  3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF,    32'h0,        32'hDEADBEEF};
        tbl[1]  = '{LD,  3'b000, 32'h203, 32'h0,        32'h80F17F00, 0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
        tbl[2]  = '{LD,  3'b100, 32'h203, 32'h0,        32'h80F17F00, 1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0,        32'h00000080};
        tbl[3]  = '{LD,  3'b001, 32'h202, 32'h0,        32'h80F17F00, 0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1100, 32'h0,        32'hFFFF80F1};
        tbl[4]  = '{LD,  3'b101, 32'h202, 32'h0,        32'h80F17F00, 3, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1100, 32'h0,        32'h000080F1};
        tbl[5]  = '{ST,  3'b000, 32'h0A1, 32'h123456AB, 32'h0,        0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 32'hABABABAB, 32'h000000A1};
        tbl[6]  = '{LD,  3'b010, 32'h102, 32'h0,        32'h0,        0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0,    32'h0,        32'h0};
        tbl[7]  = '{ADD, 3'b000, 32'h055, 32'h0,        32'h0,        0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    32'h0,        32'h00000055};
        tbl[8]  = '{ST,  3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF,    32'hCAFEF00D, 32'h00000300};
        tbl[9]  = '{ST,  3'b001, 32'h0E2, 32'h0000BEEF, 32'h0,        0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h000000E2};
        tbl[10] = '{LD,  3'b001, 32'h101, 32'h0,        32'h0,        0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0,    32'h0,        32'h0};
        tbl[11] = '{ST,  3'b010, 32'h302, 32'h1,        32'h0,        0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0,    32'h0,        32'h0};
        tbl[12] = '{LD,  3'b011, 32'h100, 32'h0,        32'h0,        0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0,    32'h0,        32'h0};
        tbl[13] = '{ST,  3'b100, 32'h104, 32'h0,        32'h0,        0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0,    32'h0,        32'h0};

        rst_n = 1'b0; valid_in = 1'b0; mem_ack = 1'b0; opcode = 7'b0;
        funct3 = 3'b0; c = 32'h0; data2 = 32'h0; mem_rdata = 32'h0;
        step(); step();
        rst_n = 1'b1;
        chk_reset_state("reset");

        for (int i = 0; i < 14; i++) run_txn(tbl[i]);

        // Spurious ack while idle must not retire anything.
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        step();
        mem_ack = 1'b0;
        chk("spurious_ack_valid", {31'b0, valid_out}, 32'd0);
        chk("spurious_ack_req", {31'b0, mem_req}, 32'd0);
        chk("spurious_ack_result", result, 32'd0);

        // Reset mid-access abandons the transaction; a late ack is ignored.
        run_txn(tbl[8]);
        opcode = LD; funct3 = 3'b010; c = 32'h400; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        chk("rst_access_req", {31'b0, mem_req}, 32'd1);
        chk("rst_access_stall", {31'b0, stall}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_reset_state("midreset");
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        step();
        mem_ack = 1'b0;
        chk("late_ack_valid", {31'b0, valid_out}, 32'd0);
        chk("late_ack_req", {31'b0, mem_req}, 32'd0);
        chk("late_ack_stall", {31'b0, stall}, 32'd0);
        model(LD, 3'b010, 32'h404, 32'h0, 32'h13572468, v);
        v.delay = 1;
        run_txn(v);

        // Instruction held on valid_in during stall is taken only after retirement.
        opcode = LD; funct3 = 3'b010; c = 32'h500; valid_in = 1'b1;
        step();
        opcode = ADD; c = 32'h77;
        chk("held_valid_out", {31'b0, valid_out}, 32'd0);
        chk("held_stall", {31'b0, stall}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h11223344;
        step();
        mem_ack = 1'b0;
        chk("held_load_valid", {31'b0, valid_out}, 32'd1);
        chk("held_load_result", result, 32'h11223344);
        step();
        valid_in = 1'b0;
        chk("held_add_valid", {31'b0, valid_out}, 32'd1);
        chk("held_add_result", result, 32'h77);
        step();
        chk("held_add_pulse", {31'b0, valid_out}, 32'd0);

        // Randomized transactions against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            int         sel;
            sel = $urandom_range(0, 9);
            op  = (sel < 4) ? LD : (sel < 7) ? ST : (sel < 9) ? ADD : 7'($urandom);
            model(op, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, v);
            v.delay = $urandom_range(0, 3);
            v.gap   = 1'($urandom_range(0, 1));
            run_txn(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage directly downstream of the execute stage. Consumes the execute result `c`, used as the effective address or pass-through value, plus store data, and runs a single-outstanding req/ack transaction on the data-memory bus for loads and stores. Holds the execute stage with `stall` while a transaction is pending, then presents a registered, aligned and extended result to the write-back stage.

## Interface
Parameters:
- `LOAD_OP`, default 7'b0000011: load opcode.
- `STORE_OP`, default 7'b0100011: store opcode.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `valid_in`  in  1: instruction from execute is valid this cycle.
- `opcode`  in  7: instruction opcode.
- `funct3`  in  3: access size/sign selector.
- `c`  in  32: execute result; the effective address for loads and stores.
- `data2`  in  32: store source data (rs2).
- `stall`  out  1: execute must hold its instruction; combinational, 1 iff state is ACCESS.
- `valid_out`  out  1: `result` valid; one-cycle pulse per retired instruction.
- `result`  out  32: load data, or `c` for non-loads.
- `mem_err`  out  1: misaligned or reserved-funct3 access; qualified by `valid_out`.
- `mem_req`  out  1: bus request.
- `mem_we`  out  1: 1 for store.
- `mem_addr`  out  32: word address, `{c[31:2],2'b00}`.
- `mem_be`  out  4: byte enables.
- `mem_wdata`  out  32: lane-replicated store data.
- `mem_ack`  in  1: bus completion; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32: load word.

## Operation
The block is a two-state machine.

IDLE:
- An instruction is accepted when `valid_in=1`.
- Non-memory opcode: `result<=c`, `valid_out<=1`, `mem_err<=0`.
- Memory opcode, legal and aligned: register `mem_req=1`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, the access kind and the byte offset, then go to ACCESS.
- Memory opcode, illegal: no request; `valid_out<=1`, `mem_err<=1`, `result<=0`.

ACCESS:
- Hold all bus outputs stable until `mem_ack=1`.
- On ack: `mem_req<=0` and `valid_out<=1`.
  - Load: `result<=` extended data.
  - Store: `result<=c` (the captured address).
- Then go to IDLE.

Legal encodings:
- Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: funct3 000 SB, 001 SH, 010 SW.
- Any other funct3 under these opcodes is illegal.

Misaligned accesses are illegal:
- Halfword with `c[0]=1`.
- Word with `c[1:0]!=0`.

Store lanes:
- SB: `mem_be=4'b0001<<c[1:0]`, wdata = `data2[7:0]` in all four bytes.
- SH: `mem_be=4'b0011<<{c[1],1'b0}`, wdata = `data2[15:0]` in both halves.
- SW: `mem_be=4'hF`, wdata = `data2`.
- Loads: `mem_be` as for the equivalent store size, `mem_we=0`.

Load extension:
- Select the byte or halfword from `mem_rdata` at the captured offset.
- LB/LH sign-extend; LBU/LHU zero-extend.

Boundary conditions:
- `mem_ack` outside ACCESS is ignored.
- `valid_in` while `stall=1` is not accepted; execute re-presents the instruction.
- `valid_out` is 0 in every cycle with no retirement.

## Timing
- Reset (`rst_n=0` at an edge): state=IDLE; `mem_req`, `mem_we`, `valid_out`, `mem_err`=0; `result`, `mem_addr`, `mem_wdata`=0; `mem_be`=0.
- Reset during ACCESS abandons the transaction. An ack arriving after reset is ignored.
- Non-memory op: 1-cycle latency; accepted at cycle N, `valid_out=1` in N+1.
- Memory op: accepted at N; `mem_req=1` from N+1.
  - If ack arrives at cycle M≥N+1: `valid_out=1` and `mem_req=0` in M+1.
  - Minimum latency is 2 cycles.
- `stall=1` in cycles N+1..M. The next instruction is accepted at M+1, back-to-back with the retirement.
- Only one transaction is outstanding at a time. `mem_req` never rises in the cycle after an ack.

## Structure
- Shared package holds:
  - Opcode constants (`LOAD_OP`, `STORE_OP`, alongside existing opcode set).
  - funct3 size encodings (BYTE=000, HALF=001, WORD=010, BYTEU=100, HALFU=101).
  - State encoding (IDLE=1'b0, ACCESS=1'b1).
- One combinational sub-module, `load_align`: inputs `mem_rdata`, offset[1:0], funct3; output extended 32-bit load value. Instantiated once; verifiable standalone.

## Test plan
- LW at `c=0x100`, ack 2 cycles after request, rdata=0xDEADBEEF:
  - `mem_addr=0x100`, `mem_be=F`.
  - `stall=1` for 3 cycles.
  - `result=0xDEADBEEF` with `valid_out` one cycle after ack.
- LB, LBU, LH, LHU at `c=0x203` and `0x202`, rdata=0x80F17F00:
  - LB@3 → 0xFFFFFF80; LBU@3 → 0x00000080.
  - LH@2 → 0xFFFF80F1; LHU@2 → 0x000080F1.
- SB at `c=0x0A1`, `data2=0x123456AB`, immediate ack:
  - `mem_we=1`, `mem_be=4'b0010`, `mem_wdata=0xABABABAB`.
  - `valid_out` two cycles after accept.
- LW at `c=0x102`: no `mem_req`; next cycle `valid_out=1`, `mem_err=1`, `result=0`, `stall` never asserted.
- ADD result `c=0x55` back-to-back with SW:
  - `result=0x55` after 1 cycle.
  - SW holds `stall` until ack.
  - A spurious `mem_ack` while IDLE has no effect.
- `rst_n=0` mid-ACCESS, then ack: all outputs reset values, no `valid_out` pulse, next LW completes normally.
